// File: rtl/spi_word_feeder_if.sv
// Host/SPI-side bundle for spi_word_feeder: FIFO write port, status, and SPI load/done handshake.
// Optional SPI_FEEDER_FRAME_CNT_EN adds the frame_cnt status output.
interface spi_word_feeder_if #(
   parameter int DATA_W = 24,
   parameter int DEPTH  = 16
);
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              enable;
   logic              clr_err;
   logic              spi_done;
   logic [DATA_W-1:0] spi_word;
   logic              spi_load;
   logic [LVL_W-1:0]  level;
   logic              full;
   logic              empty;
   logic              busy;
   logic              overflow;
   logic              timeout_err;
`ifdef SPI_FEEDER_FRAME_CNT_EN
   logic [15:0]       frame_cnt;

   modport master (
      output wr_en, wr_data, enable, clr_err, spi_done,
      input  spi_word, spi_load, level, full, empty, busy, overflow, timeout_err, frame_cnt
   );
   modport slave (
      input  wr_en, wr_data, enable, clr_err, spi_done,
      output spi_word, spi_load, level, full, empty, busy, overflow, timeout_err, frame_cnt
   );
`else
   modport master (
      output wr_en, wr_data, enable, clr_err, spi_done,
      input  spi_word, spi_load, level, full, empty, busy, overflow, timeout_err
   );
   modport slave (
      input  wr_en, wr_data, enable, clr_err, spi_done,
      output spi_word, spi_load, level, full, empty, busy, overflow, timeout_err
   );
`endif
endinterface

// File: rtl/spi_word_feeder.sv
// Word FIFO feeding the SPI controller one frame at a time with a chip-select gap between frames.
// Optional feature macro: SPI_FEEDER_FRAME_CNT_EN (adds frame_cnt, counting frames ended by spi_done).
//
// state  | meaning
// S_IDLE | waiting for enable && !empty, spi_load low
// S_SEND | spi_load high, word frozen, waiting for spi_done or timeout
// S_GAP  | spi_load low for GAP_CYCLES cycles before the next frame
module spi_word_feeder #(
   parameter int DATA_W       = 24,
   parameter int DEPTH        = 16,
   parameter int GAP_CYCLES   = 8,
   parameter int DONE_TIMEOUT = 4096
) (
   input  logic              clk,
   input  logic              rst_n,
   spi_word_feeder_if.slave  bus
);
   localparam int AW    = $clog2(DEPTH);
   localparam int LVL_W = AW + 1;
   localparam int TW    = (DONE_TIMEOUT > 1) ? $clog2(DONE_TIMEOUT) : 1;
   localparam int GW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [TW-1:0]    TMO_LAST = TW'(DONE_TIMEOUT - 1);
   localparam logic [GW-1:0]    GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

   state_t            state_q;
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]  level_q, level_d;
   logic [DATA_W-1:0] spi_word_q;
   logic              spi_load_q;
   logic [TW-1:0]     tmo_cnt_q;
   logic [GW-1:0]     gap_cnt_q;
   logic              overflow_q, timeout_q;
   logic              full, empty, push, pop, tmo_fire;

   assign full     = (level_q == LVL_FULL);
   assign empty    = (level_q == '0);
   assign push     = bus.wr_en && !full;
   assign pop      = (state_q == S_IDLE) && bus.enable && !empty;
   assign tmo_fire = (state_q == S_SEND) && !bus.spi_done && (tmo_cnt_q == TMO_LAST);

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   // Storage is not reset; pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= bus.wr_data;
   end

`ifdef SPI_FEEDER_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;
   assign bus.frame_cnt = frame_cnt_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         spi_word_q  <= '0;
         spi_load_q  <= 1'b0;
         tmo_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         overflow_q  <= 1'b0;
         timeout_q   <= 1'b0;
`ifdef SPI_FEEDER_FRAME_CNT_EN
         frame_cnt_q <= '0;
`endif
      end else begin
         level_q <= level_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;

         if (bus.wr_en && full) overflow_q <= 1'b1;
         else if (bus.clr_err)  overflow_q <= 1'b0;

         if (tmo_fire)         timeout_q <= 1'b1;
         else if (bus.clr_err) timeout_q <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (pop) begin
                  spi_word_q <= mem_q[rd_ptr_q];
                  rd_ptr_q   <= rd_ptr_q + 1'b1;
                  spi_load_q <= 1'b1;
                  tmo_cnt_q  <= '0;
                  state_q    <= S_SEND;
               end
            end
            S_SEND: begin
               if (bus.spi_done || tmo_fire) begin
                  spi_load_q <= 1'b0;
                  gap_cnt_q  <= '0;
                  state_q    <= (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
`ifdef SPI_FEEDER_FRAME_CNT_EN
                  if (bus.spi_done) frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + 1'b1;
               end
            end
            S_GAP: begin
               if (gap_cnt_q == GAP_LAST) state_q   <= S_IDLE;
               else                       gap_cnt_q <= gap_cnt_q + 1'b1;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.spi_word    = spi_word_q;
   assign bus.spi_load    = spi_load_q;
   assign bus.level       = level_q;
   assign bus.full        = full;
   assign bus.empty       = empty;
   assign bus.busy        = (state_q != S_IDLE);
   assign bus.overflow    = overflow_q;
   assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_spi_word_feeder.sv
// Directed bench for spi_word_feeder: a done responder answers 30 cycles after load, a monitor logs frames.
module tb_spi_word_feeder;
   localparam int DATA_W   = 24;
   localparam int DEPTH    = 16;
   localparam int GAP      = 8;
   localparam int TMO      = 4096;
   localparam int DONE_DLY = 30;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   spi_word_feeder_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   spi_word_feeder #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_CYCLES(GAP), .DONE_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   int total = 0;
   int bad   = 0;

   // done responder
   bit auto_done = 1'b1;
   int ld_cnt = 0;
   always @(negedge clk) begin
      if (auto_done && bus.spi_load) begin
         ld_cnt = ld_cnt + 1;
         bus.spi_done = (ld_cnt == DONE_DLY);
      end else begin
         ld_cnt = 0;
         bus.spi_done = 1'b0;
      end
   end

   // frame monitor
   logic [DATA_W-1:0] rise_q[$];
   int gap_q[$];
   int cyc = 0, fall_cyc = 0, unstable = 0;
   bit have_fall = 1'b0;
   logic prev_load = 1'b0;
   logic [DATA_W-1:0] prev_word = '0;
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.spi_load && !prev_load) begin
         rise_q.push_back(bus.spi_word);
         if (have_fall) gap_q.push_back(cyc - fall_cyc);
      end
      if (!bus.spi_load && prev_load) begin
         fall_cyc  = cyc;
         have_fall = 1'b1;
      end
      if (bus.spi_load && prev_load && bus.spi_word != prev_word) unstable = unstable + 1;
      prev_load = bus.spi_load;
      prev_word = bus.spi_word;
   end

   task automatic push(input logic [DATA_W-1:0] d);
      @(negedge clk);
      bus.wr_en = 1'b1;
      bus.wr_data = d;
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic wait_idle(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk); #1;
         if (rise_q.size() >= n && !bus.spi_load && !bus.busy) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_rise(input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (bus.spi_load) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      total++; if (bus.spi_load !== 1'b0) begin bad++; $display("FAIL rst_load got=%b exp=0", bus.spi_load); end
      total++; if (bus.spi_word !== 24'h0) begin bad++; $display("FAIL rst_word got=%h exp=000000", bus.spi_word); end
      total++; if (bus.level !== 5'd0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin
         bad++; $display("FAIL rst_fifo level=%0d empty=%b full=%b exp 0/1/0", bus.level, bus.empty, bus.full); end
      total++; if (bus.busy !== 1'b0 || bus.overflow !== 1'b0 || bus.timeout_err !== 1'b0) begin
         bad++; $display("FAIL rst_flags busy=%b ovf=%b tmo=%b exp 0/0/0", bus.busy, bus.overflow, bus.timeout_err); end
      rst_n = 1'b1;
   endtask

   task automatic test_single;
      bit ok;
      int hc, bc;
      bus.enable = 1'b1;
      push(24'hABCDEF);
      wait_rise(20, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_rise got=no_load exp=load"); end
      total++; if (bus.spi_word !== 24'hABCDEF) begin bad++; $display("FAIL single_word got=%h exp=abcdef", bus.spi_word); end
      hc = 0;
      while (bus.spi_load && hc < 200) begin @(negedge clk); hc++; end
      total++; if (hc != DONE_DLY) begin bad++; $display("FAIL single_load_len got=%0d exp=%0d", hc, DONE_DLY); end
      bc = 0;
      while (bus.busy && bc < 50) begin @(negedge clk); bc++; end
      total++; if (bc != GAP) begin bad++; $display("FAIL single_gap got=%0d exp=%0d", bc, GAP); end
      total++; if (bus.empty !== 1'b1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL single_end empty=%b busy=%b exp 1/0", bus.empty, bus.busy); end
   endtask

   task automatic test_back_to_back;
      bit ok;
      int n0, g0, u0;
      bus.enable = 1'b0;
      n0 = rise_q.size(); g0 = gap_q.size(); u0 = unstable;
      push(24'h000001); push(24'h000002); push(24'h000003);
      total++; if (bus.level !== 5'd3) begin bad++; $display("FAIL b2b_level got=%0d exp=3", bus.level); end
      bus.enable = 1'b1;
      wait_idle(n0 + 3, 500, ok);
      total++; if (!ok || rise_q.size() != n0 + 3) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", rise_q.size() - n0, 3); end
      else begin
         total++; if (rise_q[n0] !== 24'h1 || rise_q[n0+1] !== 24'h2 || rise_q[n0+2] !== 24'h3) begin
            bad++; $display("FAIL b2b_order got=%h,%h,%h exp=1,2,3", rise_q[n0], rise_q[n0+1], rise_q[n0+2]); end
         total++; if (gap_q[g0+1] < GAP + 1 || gap_q[g0+2] < GAP + 1) begin
            bad++; $display("FAIL b2b_gap got=%0d,%0d exp>=%0d", gap_q[g0+1], gap_q[g0+2], GAP + 1); end
      end
      total++; if (unstable != u0) begin bad++; $display("FAIL b2b_word_stable got=%0d changes exp=0", unstable - u0); end
      total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b exp=1", bus.empty); end
   endtask

   task automatic test_overflow;
      bit ok;
      int n0;
      bus.enable = 1'b0;
      n0 = rise_q.size();
      for (int i = 0; i < 16; i++) push(24'h000100 + 24'(i));
      total++; if (bus.level !== 5'd16 || bus.full !== 1'b1) begin
         bad++; $display("FAIL ovf_full level=%0d full=%b exp 16/1", bus.level, bus.full); end
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", bus.overflow); end
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_data = 24'h000110; bus.clr_err = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0; bus.clr_err = 1'b0;
      total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%b exp=1", bus.overflow); end
      total++; if (bus.level !== 5'd16) begin bad++; $display("FAIL ovf_level got=%0d exp=16", bus.level); end
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", bus.overflow); end
      bus.enable = 1'b1;
      wait_idle(n0 + 16, 1500, ok);
      repeat (20) @(negedge clk);
      total++; if (!ok || rise_q.size() != n0 + 16) begin bad++; $display("FAIL ovf_count got=%0d exp=16", rise_q.size() - n0); end
      else begin
         total++; if (rise_q[n0] !== 24'h100 || rise_q[n0+15] !== 24'h10F) begin
            bad++; $display("FAIL ovf_words got=%h..%h exp=000100..00010f", rise_q[n0], rise_q[n0+15]); end
      end
   endtask

   task automatic test_timeout;
      bit ok;
      int hc, bc;
      auto_done = 1'b0;
      bus.enable = 1'b1;
      push(24'h5A5A5A);
      wait_rise(20, ok);
      total++; if (!ok) begin bad++; $display("FAIL tmo_rise got=no_load exp=load"); end
      hc = 0;
      while (bus.spi_load && hc < 5000) begin @(negedge clk); hc++; end
      total++; if (hc != TMO) begin bad++; $display("FAIL tmo_len got=%0d exp=%0d", hc, TMO); end
      total++; if (bus.timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_flag got=%b exp=1", bus.timeout_err); end
      bc = 0;
      while (bus.busy && bc < 50) begin @(negedge clk); bc++; end
      total++; if (bc != GAP || bus.busy !== 1'b0) begin bad++; $display("FAIL tmo_idle gap=%0d busy=%b exp %0d/0", bc, bus.busy, GAP); end
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      total++; if (bus.timeout_err !== 1'b0) begin bad++; $display("FAIL tmo_clr got=%b exp=0", bus.timeout_err); end
      auto_done = 1'b1;
   endtask

   task automatic test_enable_hold;
      bit ok;
      int n0, k;
      bus.enable = 1'b1;
      n0 = rise_q.size();
      push(24'h0000E1); push(24'h0000E2);
      k = 0;
      while (rise_q.size() <= n0 && k < 20) begin @(negedge clk); #1; k++; end
      bus.enable = 1'b0;
      repeat (100) @(negedge clk);
      total++; if (rise_q.size() != n0 + 1 || bus.level !== 5'd1 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL en_hold frames=%0d level=%0d busy=%b exp 1/1/0", rise_q.size() - n0, bus.level, bus.busy); end
      bus.enable = 1'b1;
      wait_idle(n0 + 2, 100, ok);
      total++; if (!ok || rise_q.size() != n0 + 2 || rise_q[n0+1] !== 24'hE2) begin
         bad++; $display("FAIL en_resume frames=%0d exp=2", rise_q.size() - n0); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      int n0;
`ifdef SPI_FEEDER_FRAME_CNT_EN
      total++; if (bus.frame_cnt !== 16'd22) begin bad++; $display("FAIL fcnt_pre got=%0d exp=22", bus.frame_cnt); end
`endif
      bus.enable = 1'b0;
      push(24'h0000A1); push(24'h0000A2); push(24'h0000A3);
      bus.enable = 1'b1;
      @(negedge clk);
      wait_rise(20, ok);
      total++; if (!ok || bus.level !== 5'd2) begin bad++; $display("FAIL rmid_setup level=%0d exp=2", bus.level); end
      #2 rst_n = 1'b0;
      #1;
      total++; if (bus.spi_load !== 1'b0 || bus.level !== 5'd0 || bus.empty !== 1'b1) begin
         bad++; $display("FAIL rmid_async load=%b level=%0d empty=%b exp 0/0/1", bus.spi_load, bus.level, bus.empty); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk); #1;
      n0 = rise_q.size();
      repeat (60) @(negedge clk);
      #1;
      total++; if (rise_q.size() != n0 || bus.busy !== 1'b0) begin
         bad++; $display("FAIL rmid_quiet frames=%0d busy=%b exp 0/0", rise_q.size() - n0, bus.busy); end
   endtask

   task automatic test_same_cycle;
      bit ok;
      int n0;
      bus.enable = 1'b0;
      n0 = rise_q.size();
      push(24'h666666);
      total++; if (bus.level !== 5'd1) begin bad++; $display("FAIL same_pre got=%0d exp=1", bus.level); end
      @(negedge clk);
      bus.wr_en = 1'b1; bus.wr_data = 24'h777777; bus.enable = 1'b1;
      @(negedge clk);
      bus.wr_en = 1'b0;
      total++; if (bus.level !== 5'd1) begin bad++; $display("FAIL same_level got=%0d exp=1", bus.level); end
      total++; if (bus.spi_load !== 1'b1 || bus.spi_word !== 24'h666666) begin
         bad++; $display("FAIL same_pop load=%b word=%h exp 1/666666", bus.spi_load, bus.spi_word); end
      wait_idle(n0 + 2, 200, ok);
      total++; if (!ok || rise_q.size() != n0 + 2 || rise_q[n0+1] !== 24'h777777 || bus.empty !== 1'b1) begin
         bad++; $display("FAIL same_drain frames=%0d empty=%b exp 2/1", rise_q.size() - n0, bus.empty); end
`ifdef SPI_FEEDER_FRAME_CNT_EN
      total++; if (bus.frame_cnt !== 16'd2) begin bad++; $display("FAIL fcnt_post got=%0d exp=2", bus.frame_cnt); end
`endif
   endtask

   initial begin
      bus.wr_en = 1'b0;
      bus.wr_data = '0;
      bus.enable = 1'b0;
      bus.clr_err = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_overflow();
      test_timeout();
      test_enable_hold();
      test_reset_mid();
      test_same_cycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
